// File: rtl/level_duration_meter.sv
// Measures how long each synchronized input level is held and queues {level, duration}
// records in a small FIFO read out over a valid/ready handshake.
module level_duration_meter #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in,
    input  logic             enable,
    input  logic             ready,
    input  logic             clear_ovf,
    output logic             valid,
    output logic             level,
    output logic [WIDTH-1:0] duration,
    output logic             overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   p_q;
    logic                   edge_det;
    logic                   armed_q;
    logic [WIDTH-1:0]       cnt_q;
    logic [WIDTH-1:0]       cnt_d;
    logic                   push;

    logic [WIDTH:0]         mem_q [DEPTH];
    logic [AW:0]            wr_ptr_q;
    logic [AW:0]            rd_ptr_q;
    logic                   empty;
    logic                   full;
    logic                   pop;
    logic                   wr_en;
    logic                   drop;
    logic                   overflow_q;
    logic [WIDTH:0]         head;

    // ---------------------------------------------------------------------
    // Synchronizer, edge detection, arming and duration counter
    // ---------------------------------------------------------------------
    assign s        = sync_q[SYNC_STAGES-1];
    assign edge_det = enable && (s != p_q);
    // The arming edge has no known start time, so it never produces a record.
    assign push     = edge_det && armed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            p_q     <= 1'b0;
            armed_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], in};
            p_q     <= s;
            cnt_q   <= cnt_d;
            if (!enable) begin
                armed_q <= 1'b0;
            end else if (edge_det) begin
                armed_q <= 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!enable) begin
            cnt_d = '0;
        end else if (edge_det) begin
            cnt_d = {{(WIDTH-1){1'b0}}, 1'b1};
        end else if (armed_q && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Record FIFO
    // ---------------------------------------------------------------------
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = !empty && ready;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {p_q, cnt_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clear_ovf) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign head     = mem_q[rd_ptr_q[AW-1:0]];
    assign valid    = !empty;
    assign level    = valid ? head[WIDTH] : 1'b0;
    assign duration = valid ? head[WIDTH-1:0] : '0;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_level_duration_meter.sv
// Scoreboard bench for level_duration_meter: expected records are queued when the
// ending edge is driven and compared as the DUT hands them out.
module tb_level_duration_meter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in = 1'b0;
    logic        enable = 1'b1;
    logic        ready = 1'b0;
    logic        clear_ovf = 1'b0;
    logic        valid;
    logic        level;
    logic [15:0] duration;
    logic        overflow;

    logic        in2 = 1'b0;
    logic        en2 = 1'b1;
    logic        ready2 = 1'b0;
    logic        clr2 = 1'b0;
    logic        valid2;
    logic        level2;
    logic [3:0]  duration2;
    logic        overflow2;

    logic [16:0] sb [$];
    logic [16:0] exp_rec;
    int          checks = 0;
    int          errors = 0;

    level_duration_meter #(
        .WIDTH      (16),
        .DEPTH      (4),
        .SYNC_STAGES(2)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in),
        .enable   (enable),
        .ready    (ready),
        .clear_ovf(clear_ovf),
        .valid    (valid),
        .level    (level),
        .duration (duration),
        .overflow (overflow)
    );

    level_duration_meter #(
        .WIDTH      (4),
        .DEPTH      (4),
        .SYNC_STAGES(2)
    ) u_dut_sat (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in2),
        .enable   (en2),
        .ready    (ready2),
        .clear_ovf(clr2),
        .valid    (valid2),
        .level    (level2),
        .duration (duration2),
        .overflow (overflow2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required simulation end");
        $fatal(1);
    end

    // Records are taken at the edge following a negedge where valid && ready.
    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            checks = checks + 1;
            if (sb.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_record: got level=%0d duration=%0d, required none",
                         level, duration);
            end else begin
                exp_rec = sb.pop_front();
                if ({level, duration} !== exp_rec) begin
                    errors = errors + 1;
                    $display("FAIL record: got level=%0d duration=%0d, required level=%0d duration=%0d",
                             level, duration, exp_rec[16], exp_rec[15:0]);
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic toggle(input bit rec, input int unsigned dur);
        if (rec) sb.push_back({in, 16'(dur)});
        in = ~in;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in        = 1'b0;
        in2       = 1'b0;
        enable    = 1'b1;
        ready     = 1'b0;
        ready2    = 1'b0;
        clear_ovf = 1'b0;
        sb.delete();
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(2);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks = checks + 1;
        if ({valid, level, duration, overflow} !== 19'd0) begin
            errors = errors + 1;
            $display("FAIL reset_async: got %0h, required 0", {valid, level, duration, overflow});
        end
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(3);
        checks = checks + 1;
        if ({valid, overflow} !== 2'b00) begin
            errors = errors + 1;
            $display("FAIL reset_release: got valid/ovf=%b, required 00", {valid, overflow});
        end
    endtask

    task automatic test_basic();
        do_reset();
        ready = 1'b1;
        toggle(1'b0, 0);
        wait_cycles(10);
        toggle(1'b1, 10);
        wait_cycles(2);
        checks = checks + 1;
        if (valid !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL latency_early_1: got valid=%b, required 0", valid);
        end
        wait_cycles(1);
        checks = checks + 1;
        if ({valid, level, duration} !== {1'b1, 1'b1, 16'd10}) begin
            errors = errors + 1;
            $display("FAIL latency_1: got v=%b l=%b d=%0d, required v=1 l=1 d=10",
                     valid, level, duration);
        end
        wait_cycles(4);
        toggle(1'b1, 7);
        wait_cycles(2);
        checks = checks + 1;
        if (valid !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL latency_early_2: got valid=%b, required 0", valid);
        end
        wait_cycles(1);
        checks = checks + 1;
        if ({valid, level, duration} !== {1'b1, 1'b0, 16'd7}) begin
            errors = errors + 1;
            $display("FAIL latency_2: got v=%b l=%b d=%0d, required v=1 l=0 d=7",
                     valid, level, duration);
        end
        wait_cycles(3);
        checks = checks + 1;
        if (sb.size() != 0 || valid !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL basic_drain: got pending=%0d valid=%b, required 0 0", sb.size(), valid);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        toggle(1'b0, 0);
        wait_cycles(5);
        for (int i = 0; i < 4; i++) begin
            toggle(1'b1, 5);
            wait_cycles(5);
        end
        checks = checks + 1;
        if ({overflow, valid, level, duration} !== {1'b0, 1'b1, 1'b1, 16'd5}) begin
            errors = errors + 1;
            $display("FAIL bp_full: got ovf=%b v=%b l=%b d=%0d, required 0 1 1 5",
                     overflow, valid, level, duration);
        end
        toggle(1'b0, 5);
        wait_cycles(3);
        checks = checks + 1;
        if ({overflow, valid, level, duration} !== {1'b1, 1'b1, 1'b1, 16'd5}) begin
            errors = errors + 1;
            $display("FAIL bp_overflow: got ovf=%b v=%b l=%b d=%0d, required 1 1 1 5",
                     overflow, valid, level, duration);
        end
        ready = 1'b1;
        wait_cycles(6);
        ready = 1'b0;
        checks = checks + 1;
        if (sb.size() != 0 || {valid, level, duration} !== 18'd0) begin
            errors = errors + 1;
            $display("FAIL bp_drain: got pending=%0d v=%b l=%b d=%0d, required 0 0 0 0",
                     sb.size(), valid, level, duration);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        toggle(1'b0, 0);
        wait_cycles(5);
        for (int i = 0; i < 4; i++) begin
            toggle(1'b1, 5);
            wait_cycles(5);
        end
        toggle(1'b1, 5);
        wait_cycles(2);
        ready = 1'b1;
        wait_cycles(1);
        ready = 1'b0;
        wait_cycles(2);
        checks = checks + 1;
        if ({overflow, valid} !== 2'b01) begin
            errors = errors + 1;
            $display("FAIL push_pop_full: got ovf/valid=%b, required 01", {overflow, valid});
        end
        toggle(1'b0, 5);
        wait_cycles(3);
        checks = checks + 1;
        if (overflow !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL still_full_drop: got ovf=%b, required 1", overflow);
        end
        wait_cycles(2);
        toggle(1'b0, 5);
        wait_cycles(2);
        clear_ovf = 1'b1;
        wait_cycles(1);
        clear_ovf = 1'b0;
        checks = checks + 1;
        if (overflow !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL drop_beats_clear: got ovf=%b, required 1", overflow);
        end
        wait_cycles(2);
        clear_ovf = 1'b1;
        wait_cycles(1);
        clear_ovf = 1'b0;
        checks = checks + 1;
        if (overflow !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL clear_ovf: got ovf=%b, required 0", overflow);
        end
        ready = 1'b1;
        wait_cycles(6);
        ready = 1'b0;
        checks = checks + 1;
        if (sb.size() != 0 || valid !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL full_drain: got pending=%0d valid=%b, required 0 0", sb.size(), valid);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        ready = 1'b1;
        toggle(1'b0, 0);
        in2 = ~in2;
        wait_cycles(20);
        toggle(1'b1, 20);
        in2 = ~in2;
        wait_cycles(3);
        checks = checks + 1;
        if ({valid2, level2, duration2} !== {1'b1, 1'b1, 4'd15}) begin
            errors = errors + 1;
            $display("FAIL saturate: got v=%b l=%b d=%0d, required v=1 l=1 d=15",
                     valid2, level2, duration2);
        end
        wait_cycles(3);
        checks = checks + 1;
        if ({valid2, level2, duration2} !== {1'b1, 1'b1, 4'd15} || sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL saturate_hold: got v=%b l=%b d=%0d pending=%0d, required 1 1 15 0",
                     valid2, level2, duration2, sb.size());
        end
    endtask

    task automatic test_enable_gating();
        do_reset();
        ready = 1'b1;
        toggle(1'b0, 0);
        wait_cycles(5);
        toggle(1'b1, 5);
        wait_cycles(4);
        enable = 1'b0;
        wait_cycles(8);
        checks = checks + 1;
        if (valid !== 1'b0 || sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL enable_low: got valid=%b pending=%0d, required 0 0", valid, sb.size());
        end
        enable = 1'b1;
        wait_cycles(3);
        toggle(1'b0, 0);
        wait_cycles(6);
        toggle(1'b1, 6);
        wait_cycles(6);
        checks = checks + 1;
        if (sb.size() != 0 || valid !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL enable_record: got pending=%0d valid=%b, required 0 0",
                     sb.size(), valid);
        end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        toggle(1'b0, 0);
        wait_cycles(5);
        for (int i = 0; i < 4; i++) begin
            toggle(1'b1, 5);
            wait_cycles(5);
        end
        toggle(1'b0, 5);
        wait_cycles(5);
        ready = 1'b1;
        wait_cycles(1);
        ready = 1'b0;
        checks = checks + 1;
        if ({overflow, valid} !== 2'b11) begin
            errors = errors + 1;
            $display("FAIL pre_reset: got ovf/valid=%b, required 11", {overflow, valid});
        end
        #1 rst_n = 1'b0;
        #1;
        checks = checks + 1;
        if ({valid, level, duration, overflow} !== 19'd0) begin
            errors = errors + 1;
            $display("FAIL mid_reset_async: got %0h, required 0",
                     {valid, level, duration, overflow});
        end
        sb.delete();
        #1 rst_n = 1'b1;
        ready = 1'b1;
        wait_cycles(5);
        toggle(1'b0, 0);
        wait_cycles(5);
        checks = checks + 1;
        if (valid !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL no_stale: got valid=%b, required 0", valid);
        end
        toggle(1'b1, 5);
        wait_cycles(6);
        checks = checks + 1;
        if (sb.size() != 0 || overflow !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL post_reset_record: got pending=%0d ovf=%b, required 0 0",
                     sb.size(), overflow);
        end
        ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_full_push_pop();
        test_saturation();
        test_enable_gating();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/level_duration_meter.md
# level_duration_meter

Clocked measurement stage that sits directly downstream of the integrator filter. It synchronizes the filtered comparator level into the `clk` domain and detects each level change. It measures how many clock cycles each completed level was held and queues `{level, duration}` records in a small FIFO. Records are read out through a valid/ready handshake.

## Interface

Parameters:

- `WIDTH`, 16, duration counter and output width in bits (≥ 2).
- `DEPTH`, 4, FIFO entries; must be a power of 2 and ≥ 2.
- `SYNC_STAGES`, 2, synchronizer flops on `in` (≥ 2).

Ports:

- `clk`  input  1  sole clock, rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in`  input  1  filtered level from the integrator `out`; asynchronous to `clk`.
- `enable`  input  1  measurement enable.
- `ready`  input  1  consumer accepts the head record this cycle.
- `clear_ovf`  input  1  synchronous clear of `overflow`.
- `valid`  output  1  head record available.
- `level`  output  1  level the record describes.
- `duration`  output  WIDTH  cycles that level was held (saturating).
- `overflow`  output  1  sticky: a record was dropped.

## Operation

- **Synchronizer.** A chain of `SYNC_STAGES` flops, all reset to 0; its output is `s`. The register `p` holds the previous `s` and resets to 0.
- **Edge.** `edge = enable && (s != p)`.
- **`p` update.** `p <= s` every cycle, regardless of `enable`.
- **Armed flag.**
  - Reset value 0.
  - Cleared on any cycle with `enable` = 0.
  - Set on the first edge while enabled.
  - The arming edge itself produces no record, because the start time of that level is unknown.
- **Duration counter `cnt` (WIDTH bits).**
  - Reset value 0; held at 0 while `enable` = 0.
  - On an edge: `cnt <= 1`.
  - Otherwise, while enabled and armed: `cnt <= cnt + 1`, saturating at 2^WIDTH−1 and never wrapping.
  - Consequence: when `p` holds a level for N cycles, `cnt` equals min(N, 2^WIDTH−1) on the edge cycle that ends that level.
- **Push.** `push = edge && armed`. The record is `{p, cnt}`, i.e. the level being left and its duration.
- **FIFO.**
  - `DEPTH` entries, in-order.
  - `valid` = not empty.
  - `pop = valid && ready`.
  - Full, push, no pop: the record is dropped and `overflow` is set.
  - Full, push and pop in the same cycle: both happen, occupancy stays `DEPTH`, no overflow.
  - Empty with a push: no pop occurs that cycle; the record is visible the next cycle.
- **Outputs.**
  - `level` and `duration` show the head record while `valid` = 1, and are forced to 0 while `valid` = 0.
  - Head data is held stable while `valid && !ready`.
- **Overflow.** Set by a dropped record and cleared by `clear_ovf`. If a drop and `clear_ovf` occur in the same cycle, `overflow` stays 1.
- **Enable low.** The FIFO keeps draining normally; no new records are produced. After `enable` returns high, the first edge re-arms without producing a record.

## Timing

- **Reset.** `rst_n` low immediately, asynchronously, forces:
  - `valid`=0, `level`=0, `duration`=0, `overflow`=0;
  - FIFO empty, armed=0, `cnt`=0, `p`=0, synchronizer all 0.
- **Reset mid-operation.** All queued records are lost. Release is synchronous to the next `clk` rising edge.
- **Latency.** Suppose a transition on `in` is sampled at rising edge k, the FIFO is empty and the block is armed.
  - `s` changes after edge k+SYNC_STAGES−1.
  - The push occurs at edge k+SYNC_STAGES.
  - `valid` is high after edge k+SYNC_STAGES, i.e. SYNC_STAGES+1 clock edges including the sampling edge.
- **Throughput.** One push and one pop per cycle.
- **Minimum measurable level.** 1 cycle of `s`. Pulses narrower than the synchronizer can resolve may be missed; the upstream integrator guarantees minimum width.
- **Registered outputs.** `valid`, `overflow` and the FIFO state are registered. `level` and `duration` are a registered-state mux: the FIFO head gated by `valid`.

## Test plan

All scenarios use the defaults (`WIDTH`=16, `DEPTH`=4, `SYNC_STAGES`=2) unless stated.

1. **Basic measurement.** `enable`=1, `ready`=1. `in` rises, falls 10 cycles later, rises 7 cycles later.
   - The first rise produces no record.
   - Then records `{1,10}` and `{0,7}` are produced.
   - Each record's `valid` rises 3 edges after the corresponding `in` transition is sampled.
2. **Backpressure and overflow.** `ready`=0, then the arming edge plus 5 more edges spaced 5 cycles apart.
   - 4 records are stored; `overflow`=1 after the 5th.
   - Then `ready`=1: exactly 4 records drain in order, all with `duration`=5, levels alternating; then `valid`=0 and the outputs read 0.
3. **Full with simultaneous push/pop.** FIFO at 4 entries, `ready`=1 on the same cycle as a push.
   - Occupancy stays 4 and `overflow` stays 0.
   - Separately: `clear_ovf`=1 on the same cycle as a drop leaves `overflow`=1; `clear_ovf` alone clears it.
4. **Saturation.** Instance with `WIDTH`=4, `in` held at one level for 20 cycles between edges: the record has `duration`=15.
5. **Enable gating.** Drop `enable` for 8 cycles in mid-level, raise it, then toggle `in` twice 6 cycles apart.
   - No record is produced for the interrupted level, nor for the first edge after re-enable.
   - The second edge gives `duration`=6.
6. **Reset mid-operation.** Pulse `rst_n` low for less than one clock period while 3 records are queued and `overflow`=1.
   - All outputs go to 0 immediately, without waiting for a clock edge.
   - After release, the next edge only arms the block; no stale record ever appears.
